// File: rtl/bsg_mac_issue_ctrl.sv
// rtl/bsg_mac_issue_ctrl.sv - credit-based issue controller for a fixed-latency MAC datapath
// Optional completed-operation counter: define BSG_MAC_ISSUE_CTRL_OPS_CNT_EN.
module bsg_mac_issue_ctrl #(
  parameter int width_p = 32,
  parameter int lat_p   = 1,
  parameter int els_p   = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic [2*width_p-1:0]   c_i,
  output logic                   ready_o,
  output logic [width_p-1:0]     dp_a_o,
  output logic [width_p-1:0]     dp_b_o,
  output logic [2*width_p-1:0]   dp_c_o,
  input  logic [2*width_p-1:0]   dp_s_i,
  output logic                   v_o,
  output logic [2*width_p-1:0]   s_o,
  input  logic                   yumi_i,
  output logic [31:0]            ops_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);

  logic [lat_p-1:0]       pipe_q, pipe_d;
  logic [cnt_w-1:0]       occ_q, occ_d;
  logic [ptr_w-1:0]       head_q, head_d, tail_q, tail_d;
  logic [2*width_p-1:0]   mem_q [els_p];
  logic [31:0]            used;
  logic                   accept, push, pop;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign dp_a_o = a_i;
  assign dp_b_o = b_i;
  assign dp_c_o = c_i;

  // Every set in the pipe owns a buffer slot, so the push can never overflow.
  always_comb begin
    used = 32'(occ_q);
    for (int i = 0; i < lat_p; i++) begin
      used = used + 32'(pipe_q[i]);
    end
  end

  assign ready_o = ~reset_i & (used < 32'(els_p));
  assign accept  = v_i & ready_o;
  assign push    = pipe_q[lat_p-1];
  assign v_o     = (occ_q != '0);
  assign pop     = yumi_i & v_o;
  assign s_o     = mem_q[head_q];

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = accept;
    for (int i = 1; i < lat_p; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    occ_d  = occ_q + cnt_w'(push) - cnt_w'(pop);
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipe_q <= '0;
      occ_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      pipe_q <= pipe_d;
      occ_q  <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && push) begin
      mem_q[tail_q] <= dp_s_i;
    end
  end

`ifdef BSG_MAC_ISSUE_CTRL_OPS_CNT_EN
  logic [31:0] ops_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ops_q <= '0;
    end else if (pop) begin
      ops_q <= ops_q + 32'd1;
    end
  end

  assign ops_o = ops_q;
`else
  assign ops_o = '0;
`endif

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && yumi_i && !v_o) begin
      $error("bsg_mac_issue_ctrl: yumi_i asserted while v_o=0");
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mac_issue_ctrl.sv
// tb/tb_bsg_mac_issue_ctrl.sv - directed self-checking bench for bsg_mac_issue_ctrl
module tb_bsg_mac_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset_i, v_i, yumi_i;
  logic [31:0] a_i, b_i;
  logic [63:0] c_i;
  logic        ready_o, v_o;
  logic [31:0] dp_a_o, dp_b_o, ops_o;
  logic [63:0] dp_c_o, dp_s_i, s_o;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  always #5 clk = ~clk;

  // One-stage datapath model: sum appears one cycle after the operands.
  always @(posedge clk) dp_s_i <= 64'(dp_a_o) * 64'(dp_b_o) + dp_c_o;

  bsg_mac_issue_ctrl #(.width_p(32), .lat_p(1), .els_p(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .a_i(a_i), .b_i(b_i), .c_i(c_i),
    .ready_o(ready_o), .dp_a_o(dp_a_o), .dp_b_o(dp_b_o), .dp_c_o(dp_c_o),
    .dp_s_i(dp_s_i), .v_o(v_o), .s_o(s_o), .yumi_i(yumi_i), .ops_o(ops_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ops_exp(input int n);
`ifdef BSG_MAC_ISSUE_CTRL_OPS_CNT_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  task automatic test_reset();
    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0; a_i = '0; b_i = '0; c_i = '0;
    tick(); tick();
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", ready_o); end
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v got=%0b want=0", v_o); end
    total++; if (ops_o !== 32'd0) begin bad++; $display("FAIL reset_ops got=%0d want=0", ops_o); end
    reset_i = 1'b0;
    pops = 0;
    tick();
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%0b want=1", ready_o); end
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL post_reset_v got=%0b want=0", v_o); end
  endtask

  task automatic test_single();
    a_i = 32'd3; b_i = 32'd5; c_i = 64'd7; v_i = 1'b1;
    #1;
    total++; if (dp_a_o !== 32'd3 || dp_b_o !== 32'd5 || dp_c_o !== 64'd7) begin
      bad++; $display("FAIL passthru got=%0d,%0d,%0d want=3,5,7", dp_a_o, dp_b_o, dp_c_o);
    end
    tick();
    v_i = 1'b0; a_i = 32'd99; b_i = 32'd99; c_i = 64'd99;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL single_early_v got=%0b want=0", v_o); end
    tick();
    for (int k = 0; k < 3; k++) begin
      total++; if (v_o !== 1'b1 || s_o !== 64'h16) begin
        bad++; $display("FAIL single_hold%0d got v=%0b s=%h want v=1 s=16", k, v_o, s_o);
      end
      tick();
    end
    yumi_i = 1'b1; pops++;
    tick();
    yumi_i = 1'b0;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL single_pop_v got=%0b want=0", v_o); end
  endtask

  task automatic test_full_credit();
    a_i = 32'hFFFF_FFFF; b_i = 32'hFFFF_FFFF; c_i = 64'd1; v_i = 1'b1;
    tick();
    total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL full_c1_ready got=%0b want=1", ready_o); end
    tick();
    v_i = 1'b0;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL full_c2_ready got=%0b want=0", ready_o); end
    tick(); tick();
    total++; if (ready_o !== 1'b0 || v_o !== 1'b1 || s_o !== 64'hFFFF_FFFE_0000_0002) begin
      bad++; $display("FAIL full_held got r=%0b v=%0b s=%h want r=0 v=1 s=fffffffe00000002", ready_o, v_o, s_o);
    end
    yumi_i = 1'b1; pops++;
    tick();
    yumi_i = 1'b0;
    total++; if (ready_o !== 1'b1 || v_o !== 1'b1 || s_o !== 64'hFFFF_FFFE_0000_0002) begin
      bad++; $display("FAIL full_after_pop got r=%0b v=%0b s=%h want r=1 v=1 s=fffffffe00000002", ready_o, v_o, s_o);
    end
  endtask

  task automatic test_push_pop_same();
    // One entry still buffered; new set 2*3+4=10.
    a_i = 32'd2; b_i = 32'd3; c_i = 64'd4; v_i = 1'b1;
    tick();
    v_i = 1'b0;
    total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL pp_ready got=%0b want=0", ready_o); end
    yumi_i = 1'b1; pops++;
    tick();
    total++; if (v_o !== 1'b1 || s_o !== 64'd10 || ready_o !== 1'b1) begin
      bad++; $display("FAIL pp_after got v=%0b s=%0d r=%0b want v=1 s=10 r=1", v_o, s_o, ready_o);
    end
    a_i = 32'd4; b_i = 32'd5; c_i = 64'd6; v_i = 1'b1; pops++;
    tick();
    v_i = 1'b0; yumi_i = 1'b0;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL pp_empty got=%0b want=0", v_o); end
    tick();
    total++; if (v_o !== 1'b1 || s_o !== 64'd26) begin
      bad++; $display("FAIL pp_second got v=%0b s=%0d want v=1 s=26", v_o, s_o);
    end
    yumi_i = 1'b1; pops++;
    tick();
    yumi_i = 1'b0;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL pp_drain got=%0b want=0", v_o); end
    total++; if (ops_o !== ops_exp(pops)) begin bad++; $display("FAIL pp_ops got=%0d want=%0d", ops_o, ops_exp(pops)); end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 100 && got < 8; cyc++) begin
      if (v_o) begin
        total++; if (s_o !== 64'(got * (got + 1) + 100)) begin
          bad++; $display("FAIL stream%0d got=%0d want=%0d", got, s_o, got * (got + 1) + 100);
        end
        yumi_i = 1'b1; got++; pops++;
      end else begin
        yumi_i = 1'b0;
      end
      if (sent < 8 && ready_o) begin
        v_i = 1'b1; a_i = 32'(sent); b_i = 32'(sent + 1); c_i = 64'd100; sent++;
      end else begin
        v_i = 1'b0;
      end
      tick();
    end
    v_i = 1'b0; yumi_i = 1'b0;
    total++; if (got !== 8) begin bad++; $display("FAIL stream_count got=%0d want=8", got); end
  endtask

  task automatic test_reset_flush();
    a_i = 32'd7; b_i = 32'd7; c_i = 64'd0; v_i = 1'b1;
    tick();
    v_i = 1'b0; reset_i = 1'b1;
    tick();
    reset_i = 1'b0; pops = 0;
    for (int k = 0; k < 5; k++) begin
      total++; if (v_o !== 1'b0 || ops_o !== 32'd0) begin
        bad++; $display("FAIL flush%0d got v=%0b ops=%0d want v=0 ops=0", k, v_o, ops_o);
      end
      tick();
    end
  endtask

  task automatic test_ops();
    for (int n = 0; n < 3; n++) begin
      a_i = 32'(n); b_i = 32'd2; c_i = 64'd1; v_i = 1'b1;
      tick();
      v_i = 1'b0;
      tick();
      total++; if (v_o !== 1'b1 || s_o !== 64'(2 * n + 1)) begin
        bad++; $display("FAIL ops_res%0d got v=%0b s=%0d want v=1 s=%0d", n, v_o, s_o, 2 * n + 1);
      end
      yumi_i = 1'b1; pops++;
      tick();
      yumi_i = 1'b0;
    end
    total++; if (ops_o !== ops_exp(3)) begin bad++; $display("FAIL ops_count got=%0d want=%0d", ops_o, ops_exp(3)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_credit();
    test_push_pop_same();
    test_stream();
    test_reset_flush();
    test_ops();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
